// File: rtl/sec_cnt_bcd_decode_pkg.sv
// Shared constants and state encoding for the seconds-of-day to BCD decoder.
package sec_cnt_bcd_decode_pkg;

    // Place weights of each BCD digit, expressed in seconds
    localparam logic [16:0] WeightH10 = 17'd36000;
    localparam logic [16:0] WeightH1  = 17'd3600;
    localparam logic [16:0] WeightM10 = 17'd600;
    localparam logic [16:0] WeightM1  = 17'd60;
    localparam logic [16:0] WeightS10 = 17'd10;

    // Last legal seconds-of-day value (23:59:59)
    localparam logic [16:0] SecMax = 17'd86399;

    // Seven-segment driver code for a dark digit
    localparam logic [3:0] BlankCode = 4'hF;

    typedef enum logic [2:0] {
        StIdle,
        StH10,
        StH1,
        StM10,
        StM1,
        StS10,
        StDone
    } state_e;

endpackage

// File: rtl/cw_cmp_sub.sv
// Compare-and-subtract step: flags remainder >= weight and yields the
// reduced remainder; when the weight does not fit the remainder passes through.
module cw_cmp_sub (
    input  logic [16:0] rem_i,
    input  logic [16:0] weight_i,
    output logic        ge_o,
    output logic [16:0] diff_o
);

    // Never wraps: subtraction is only selected when the weight fits
    always_comb begin
        ge_o   = (rem_i >= weight_i);
        diff_o = ge_o ? (rem_i - weight_i) : rem_i;
    end

endmodule

// File: rtl/sec_cnt_bcd_decode.sv
// Decodes a 17-bit seconds-of-day count into HH:MM:SS BCD digits by repeated
// subtraction of each digit weight, one subtraction or phase step per cycle.
// Optional feature: define SEC2BCD_LEADING_BLANK_EN to show a zero hour-tens
// digit as the blank code on valid conversions.
module sec_cnt_bcd_decode
    import sec_cnt_bcd_decode_pkg::*;
(
    input  logic        Clk,
    input  logic        pRst,
    input  logic        i_Start,
    input  logic [16:0] i_Sec_Cnt,
    output logic        o_Busy,
    output logic        o_Done,
    output logic        o_Err,
    output logic [3:0]  o_Hour_Tens,
    output logic [3:0]  o_Hour_Ones,
    output logic [3:0]  o_Min_Tens,
    output logic [3:0]  o_Min_Ones,
    output logic [3:0]  o_Sec_Tens,
    output logic [3:0]  o_Sec_Ones
);

`ifdef SEC2BCD_LEADING_BLANK_EN
    localparam logic LeadBlank = 1'b1;
`else
    localparam logic LeadBlank = 1'b0;
`endif

    state_e      state_q, state_d;
    logic [16:0] rem_q, rem_d;
    logic [3:0]  h10_q, h10_d, h1_q, h1_d, m10_q, m10_d, m1_q, m1_d, s10_q, s10_d;
    logic [16:0] weight;
    logic        ge;
    logic [16:0] diff;
    logic [3:0]  hour_tens_disp;

    cw_cmp_sub u_cmp_sub (
        .rem_i    (rem_q),
        .weight_i (weight),
        .ge_o     (ge),
        .diff_o   (diff)
    );

    // Select the weight of the digit currently being counted
    always_comb begin
        weight = 17'd0;
        case (state_q)
            StH10:   weight = WeightH10;
            StH1:    weight = WeightH1;
            StM10:   weight = WeightM10;
            StM1:    weight = WeightM1;
            StS10:   weight = WeightS10;
            default: weight = 17'd0;
        endcase
    end

    // Next state: either subtract one weight and bump the digit, or move on
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        h10_d   = h10_q;
        h1_d    = h1_q;
        m10_d   = m10_q;
        m1_d    = m1_q;
        s10_d   = s10_q;
        case (state_q)
            StIdle: begin
                if (i_Start) begin
                    rem_d   = i_Sec_Cnt;
                    h10_d   = 4'd0;
                    h1_d    = 4'd0;
                    m10_d   = 4'd0;
                    m1_d    = 4'd0;
                    s10_d   = 4'd0;
                    state_d = (i_Sec_Cnt > SecMax) ? StDone : StH10;
                end
            end
            StH10: begin
                if (ge) begin
                    rem_d = diff;
                    h10_d = h10_q + 4'd1;
                end else begin
                    state_d = StH1;
                end
            end
            StH1: begin
                if (ge) begin
                    rem_d = diff;
                    h1_d  = h1_q + 4'd1;
                end else begin
                    state_d = StM10;
                end
            end
            StM10: begin
                if (ge) begin
                    rem_d = diff;
                    m10_d = m10_q + 4'd1;
                end else begin
                    state_d = StM1;
                end
            end
            StM1: begin
                if (ge) begin
                    rem_d = diff;
                    m1_d  = m1_q + 4'd1;
                end else begin
                    state_d = StS10;
                end
            end
            StS10: begin
                if (ge) begin
                    rem_d = diff;
                    s10_d = s10_q + 4'd1;
                end else begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Hour-tens display value, optionally blanked when zero
    always_comb begin
        hour_tens_disp = h10_q;
        if (LeadBlank && (h10_q == 4'd0)) begin
            hour_tens_disp = BlankCode;
        end
    end

    // State, working registers and the held display outputs. Outputs load on
    // the edge entering DONE so they are valid in the same cycle as o_Done.
    // Entering DONE straight from IDLE is the out-of-range path: flag only.
    always_ff @(posedge Clk) begin
        if (pRst) begin
            state_q     <= StIdle;
            rem_q       <= 17'd0;
            h10_q       <= 4'd0;
            h1_q        <= 4'd0;
            m10_q       <= 4'd0;
            m1_q        <= 4'd0;
            s10_q       <= 4'd0;
            o_Err       <= 1'b0;
            o_Hour_Tens <= 4'd0;
            o_Hour_Ones <= 4'd0;
            o_Min_Tens  <= 4'd0;
            o_Min_Ones  <= 4'd0;
            o_Sec_Tens  <= 4'd0;
            o_Sec_Ones  <= 4'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            h10_q   <= h10_d;
            h1_q    <= h1_d;
            m10_q   <= m10_d;
            m1_q    <= m1_d;
            s10_q   <= s10_d;
            if (state_d == StDone) begin
                if (state_q == StIdle) begin
                    o_Err <= 1'b1;
                end else begin
                    o_Err       <= 1'b0;
                    o_Hour_Tens <= hour_tens_disp;
                    o_Hour_Ones <= h1_q;
                    o_Min_Tens  <= m10_q;
                    o_Min_Ones  <= m1_q;
                    o_Sec_Tens  <= s10_q;
                    o_Sec_Ones  <= rem_q[3:0];
                end
            end
        end
    end

    // Status flags decoded from the state register
    always_comb begin
        o_Busy = (state_q != StIdle);
        o_Done = (state_q == StDone);
    end

endmodule

// File: tb/tb_sec_cnt_bcd_decode.sv
// Directed bench for sec_cnt_bcd_decode with a queue-based scoreboard.
// Honours SEC2BCD_LEADING_BLANK_EN for the expected hour-tens digit.
module tb_sec_cnt_bcd_decode;

    logic        Clk;
    logic        pRst;
    logic        i_Start;
    logic [16:0] i_Sec_Cnt;
    logic        o_Busy, o_Done, o_Err;
    logic [3:0]  o_Hour_Tens, o_Hour_Ones, o_Min_Tens, o_Min_Ones, o_Sec_Tens, o_Sec_Ones;

    sec_cnt_bcd_decode dut (
        .Clk         (Clk),
        .pRst        (pRst),
        .i_Start     (i_Start),
        .i_Sec_Cnt   (i_Sec_Cnt),
        .o_Busy      (o_Busy),
        .o_Done      (o_Done),
        .o_Err       (o_Err),
        .o_Hour_Tens (o_Hour_Tens),
        .o_Hour_Ones (o_Hour_Ones),
        .o_Min_Tens  (o_Min_Tens),
        .o_Min_Ones  (o_Min_Ones),
        .o_Sec_Tens  (o_Sec_Tens),
        .o_Sec_Ones  (o_Sec_Ones)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int          lat;
        logic [23:0] digits;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [23:0] last_disp;
    int          tests;
    int          fails;
    int          done_cnt;
    int          last_busy;

    always @(negedge Clk) begin
        if (o_Done === 1'b1) done_cnt <= done_cnt + 1;
    end

    function automatic logic [23:0] dout();
        return {o_Hour_Tens, o_Hour_Ones, o_Min_Tens, o_Min_Ones, o_Sec_Tens, o_Sec_Ones};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference via integer division, independent of the subtractor datapath
    function automatic exp_t model(input int v);
        exp_t e;
        int   h, m, s;
        logic [3:0] ht, ho, mt, mo, st, so, htd;
        if (v > 86399) begin
            e.lat    = 1;
            e.digits = last_disp;
            e.err    = 1'b1;
            return e;
        end
        h  = v / 3600;
        m  = (v % 3600) / 60;
        s  = v % 60;
        ht = 4'(h / 10);
        ho = 4'(h % 10);
        mt = 4'(m / 10);
        mo = 4'(m % 10);
        st = 4'(s / 10);
        so = 4'(s % 10);
        htd = ht;
`ifdef SEC2BCD_LEADING_BLANK_EN
        if (ht == 4'd0) htd = 4'hF;
`endif
        e.lat    = 6 + int'(ht) + int'(ho) + int'(mt) + int'(mo) + int'(st);
        e.digits = {htd, ho, mt, mo, st, so};
        e.err    = 1'b0;
        last_disp = e.digits;
        return e;
    endfunction

    // Launch one conversion from IDLE; optional extra i_Start pulses in cycles pa/pb
    task automatic convert(input string tag, input int v, input int pa, input int pb);
        exp_t e;
        int   n;
        int   busy_n;
        exp_q.push_back(model(v));
        i_Sec_Cnt = 17'(v);
        i_Start   = 1'b1;
        n         = 0;
        busy_n    = 0;
        while (n < 100) begin
            @(negedge Clk);
            n++;
            i_Start = (n == pa || n == pb);
            if (o_Busy) busy_n++;
            if (o_Done) break;
        end
        i_Start   = 1'b0;
        last_busy = busy_n;
        check({tag, "_done_seen"}, 32'(o_Done), 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_scoreboard_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_latency"}, 32'(n), 32'(e.lat));
            check({tag, "_digits"}, 32'(dout()), 32'(e.digits));
            check({tag, "_err"}, 32'(o_Err), 32'(e.err));
            check({tag, "_busy_in_done"}, 32'(o_Busy), 32'd1);
        end
        @(negedge Clk);
        check({tag, "_done_one_cycle"}, 32'(o_Done), 32'd0);
    endtask

    initial begin
        int dc0;
        tests     = 0;
        fails     = 0;
        done_cnt  = 0;
        last_disp = 24'h0;
        pRst      = 1'b1;
        i_Start   = 1'b1;
        i_Sec_Cnt = 17'd45296;
        repeat (3) @(negedge Clk);
        i_Start = 1'b0;
        pRst    = 1'b0;
        check("reset_digits", 32'(dout()), 32'd0);
        check("reset_busy", 32'(o_Busy), 32'd0);
        check("reset_done", 32'(o_Done), 32'd0);
        check("reset_err", 32'(o_Err), 32'd0);
        @(negedge Clk);

        convert("zero", 0, -1, -1);
        convert("max", 86399, -1, -1);
        check("max_busy_cycles", 32'(last_busy), 32'd30);
        convert("overflow", 86400, -1, -1);
        convert("t3660", 3660, -1, -1);
        convert("t45296", 45296, -1, -1);

        // Error, then a valid conversion must clear it
        convert("overflow2", 131071, -1, -1);
        convert("after_err", 45296, -1, -1);

        // Starts during a busy conversion are dropped
        dc0 = done_cnt;
        convert("ignore", 3725, 2, 5);
        repeat (40) @(negedge Clk);
        check("ignore_single_done", 32'(done_cnt - dc0), 32'd1);
        check("ignore_idle", 32'(o_Busy), 32'd0);

        // Reset in cycle 3 of a conversion
        dc0       = done_cnt;
        i_Sec_Cnt = 17'd3660;
        i_Start   = 1'b1;
        @(negedge Clk);
        i_Start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        pRst = 1'b1;
        @(negedge Clk);
        pRst = 1'b0;
        check("abort_busy", 32'(o_Busy), 32'd0);
        check("abort_done", 32'(o_Done), 32'd0);
        check("abort_digits", 32'(dout()), 32'd0);
        check("abort_err", 32'(o_Err), 32'd0);
        repeat (30) @(negedge Clk);
        check("abort_no_done", 32'(done_cnt - dc0), 32'd0);
        last_disp = 24'h0;

        convert("post_reset", 86399, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
